// File: rtl/fp_div_srt_mant.sv
// fp_div_srt_mant
//   Mantissa divider for IEEE-754 single precision. Divides 1.dividend_mant
//   by 1.divisor_mant with a radix-2 SRT recurrence (digits -1/0/+1, one per
//   cycle, 26 cycles). A correction cycle converts the redundant quotient
//   into an exact floor quotient and a non-negative remainder. A rounding
//   cycle normalises, rounds to nearest-even and packs the result with the
//   exponent and sign supplied by the upstream stages.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   rst            synchronous active-high reset
//   in_valid       operand set valid
//   in_ready       block idle and able to accept operands
//   dividend_mant  dividend fraction (hidden 1 implied)
//   divisor_mant   divisor fraction (hidden 1 implied)
//   exp_in         biased quotient exponent from the exponent stage
//   sign_in        quotient sign
//   out_valid      result valid, held until accepted
//   out_ready      consumer accepts the result
//   result         packed single-precision {sign, exp, mant}
//
// Exponent arithmetic wraps modulo 256; special operands are not detected.

module fp_div_srt_mant (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [22:0] dividend_mant,
  input  logic [22:0] divisor_mant,
  input  logic [7:0]  exp_in,
  input  logic        sign_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  localparam int         REM_W    = 28;
  localparam int         Q_W      = 26;
  localparam logic [4:0] LAST_ITR = 5'd25;

  typedef enum logic [2:0] {IDLE, ITER, CORR, ROUND, DONE} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic        [4:0]         r_cnt;
  logic signed [REM_W-1:0]   r_w;
  logic        [24:0]        r_dd;
  logic        [Q_W-1:0]     r_qpos;
  logic        [Q_W-1:0]     r_qneg;
  logic        [Q_W-1:0]     r_q;
  logic signed [REM_W-1:0]   r_rem;
  logic        [7:0]         r_exp;
  logic                      r_sign;
  logic        [31:0]        r_result;

  logic signed [REM_W-1:0]   w_w2;
  logic signed [REM_W-1:0]   w_dd;
  logic signed [REM_W-1:0]   w_w_nxt;
  logic                      w_qp;
  logic                      w_qn;
  logic        [Q_W-1:0]     w_qraw;

  // Normalise, round to nearest-even and pack. A mantissa carry-out bumps
  // the exponent; both exponent adjustments wrap modulo 256.
  function automatic logic [31:0] round_pack(input logic       s,
                                             input logic [7:0] e_in,
                                             input logic [25:0] q,
                                             input logic       rem_nz);
    logic [22:0] mant;
    logic        guard;
    logic        sticky;
    logic [7:0]  e;
    if (q[25]) begin
      mant   = q[24:2];
      guard  = q[1];
      sticky = q[0] | rem_nz;
      e      = e_in;
    end else begin
      mant   = q[23:1];
      guard  = q[0];
      sticky = rem_nz;
      e      = e_in - 8'd1;
    end
    if (guard && (sticky || mant[0])) begin
      if (&mant) begin
        mant = '0;
        e    = e + 8'd1;
      end else begin
        mant = mant + 23'd1;
      end
    end
    return {s, e, mant};
  endfunction

  // Control FSM
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)          w_state_nxt = ITER;
      ITER:    if (r_cnt == LAST_ITR) w_state_nxt = CORR;
      CORR:                           w_state_nxt = ROUND;
      ROUND:                          w_state_nxt = DONE;
      DONE:    if (out_ready)         w_state_nxt = IDLE;
      default:                        w_state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;

  // Fixed point (25 fraction bits): w0 = X/4 and d = D/2 in [0.5,1), so
  // |w| <= d holds throughout. Selection looks only at 2w truncated to one
  // fraction bit: estimate >= 0 picks +1, estimate == -1/2 picks 0, and
  // anything lower picks -1. The truncation error (< 1/2) stays inside the
  // overlap regions because d >= 1/2.
  assign w_w2    = {r_w[REM_W-2:0], 1'b0};
  assign w_dd    = signed'({3'b000, r_dd});
  assign w_qp    = ~w_w2[REM_W-1];
  assign w_qn    = w_w2[REM_W-1] & (w_w2[REM_W-1:REM_W-4] != 4'b1111);
  assign w_w_nxt = w_qp ? (w_w2 - w_dd) : (w_qn ? (w_w2 + w_dd) : w_w2);
  assign w_qraw  = r_qpos - r_qneg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_w      <= '0;
      r_dd     <= '0;
      r_qpos   <= '0;
      r_qneg   <= '0;
      r_q      <= '0;
      r_rem    <= '0;
      r_exp    <= '0;
      r_sign   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        // Operand capture
        IDLE: begin
          if (in_valid) begin
            r_w    <= signed'({4'b0000, 1'b1, dividend_mant});
            r_dd   <= {1'b1, divisor_mant, 1'b0};
            r_exp  <= exp_in;
            r_sign <= sign_in;
            r_cnt  <= '0;
            r_qpos <= '0;
            r_qneg <= '0;
          end
        end
        // SRT iteration
        ITER: begin
          r_w    <= w_w_nxt;
          r_qpos <= {r_qpos[Q_W-2:0], w_qp};
          r_qneg <= {r_qneg[Q_W-2:0], w_qn};
          r_cnt  <= r_cnt + 5'd1;
        end
        // Redundant-to-binary conversion and remainder sign fix-up
        CORR: begin
          if (r_w[REM_W-1]) begin
            r_q   <= w_qraw - 26'd1;
            r_rem <= r_w + w_dd;
          end else begin
            r_q   <= w_qraw;
            r_rem <= r_w;
          end
        end
        // Round and pack
        ROUND: begin
          r_result <= round_pack(r_sign, r_exp, r_q, (r_rem != '0));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_srt_mant.sv
module tb_fp_div_srt_mant;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] dividend_mant;
  logic [22:0] divisor_mant;
  logic [7:0]  exp_in;
  logic        sign_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  fp_div_srt_mant dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .dividend_mant (dividend_mant),
    .divisor_mant  (divisor_mant),
    .exp_in        (exp_in),
    .sign_in       (sign_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [22:0] dvd;
    logic [22:0] dvs;
    logic [7:0]  e;
    logic        s;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[12];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Waits (bounded) for out_valid; returns the number of rising edges seen.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input vec_t v, input string name, input bit ready_early);
    int n;
    check({name, " in_ready before"}, {31'b0, in_ready}, 32'd1);
    dividend_mant = v.dvd;
    divisor_mant  = v.dvs;
    exp_in        = v.e;
    sign_in       = v.s;
    in_valid      = 1'b1;
    out_ready     = ready_early;
    @(negedge clk);
    in_valid      = 1'b0;
    // operands changed after transfer must not matter
    dividend_mant = ~v.dvd;
    divisor_mant  = ~v.dvs;
    exp_in        = ~v.e;
    sign_in       = ~v.s;
    wait_valid(n);
    check({name, " latency"}, n, 32'd28);
    check({name, " result"}, result, v.res);
    check({name, " in_ready while valid"}, {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " in_ready after"}, {31'b0, in_ready}, 32'd1);
    check({name, " out_valid after"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    int n;
    vecs[0]  = '{23'h000000, 23'h000000, 8'd127, 1'b0, 32'h3F800000};
    vecs[1]  = '{23'h000000, 23'h400000, 8'd127, 1'b0, 32'h3F2AAAAB};
    vecs[2]  = '{23'h400000, 23'h000000, 8'd128, 1'b1, 32'hC0400000};
    vecs[3]  = '{23'h000000, 23'h000001, 8'd127, 1'b0, 32'h3F7FFFFE};
    vecs[4]  = '{23'h000000, 23'h200000, 8'd127, 1'b0, 32'h3F4CCCCD};
    vecs[5]  = '{23'h000000, 23'h600000, 8'd127, 1'b0, 32'h3F124925};
    vecs[6]  = '{23'h600000, 23'h000000, 8'd130, 1'b0, 32'h41600000};
    vecs[7]  = '{23'h400000, 23'h400000, 8'd127, 1'b1, 32'hBF800000};
    vecs[8]  = '{23'h7FFFFF, 23'h000000, 8'd127, 1'b0, 32'h3FFFFFFF};
    vecs[9]  = '{23'h000000, 23'h7FFFFF, 8'd127, 1'b0, 32'h3F000001};
    vecs[10] = '{23'h000000, 23'h400000, 8'd0,   1'b0, 32'h7FAAAAAB};
    vecs[11] = '{23'h000000, 23'h000000, 8'd255, 1'b0, 32'h7F800000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend_mant = '0; divisor_mant = '0; exp_in = '0; sign_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset in_ready", {31'b0, in_ready}, 32'd1);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset result", result, 32'h0);

    // first transfer on the first edge with rst low
    rst = 1'b0;
    for (int i = 0; i < 12; i++)
      run_op(vecs[i], $sformatf("vec%0d", i), (i % 3) == 2);

    // backpressure in DONE with an in_valid pulse that must be ignored
    dividend_mant = '0; divisor_mant = '0; exp_in = 8'd127; sign_in = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(n);
    check("bp latency", n, 32'd28);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp result c%0d", i), result, 32'h3F800000);
      check($sformatf("bp in_ready c%0d", i), {31'b0, in_ready}, 32'd0);
      check($sformatf("bp out_valid c%0d", i), {31'b0, out_valid}, 32'd1);
      if (i == 3) begin
        dividend_mant = 23'h400000; exp_in = 8'd3; in_valid = 1'b1;
      end
      if (i == 4) in_valid = 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp in_ready after", {31'b0, in_ready}, 32'd1);
    check("bp out_valid after", {31'b0, out_valid}, 32'd0);
    repeat (3) @(negedge clk);
    check("bp no queued op in_ready", {31'b0, in_ready}, 32'd1);
    check("bp no queued op out_valid", {31'b0, out_valid}, 32'd0);

    // reset during ITER, with a stray in_valid pulse mid-iteration
    dividend_mant = '0; divisor_mant = 23'h400000; exp_in = 8'd127; sign_in = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("iter in_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst-iter out_valid", {31'b0, out_valid}, 32'd0);
    check("rst-iter in_ready", {31'b0, in_ready}, 32'd1);
    run_op(vecs[0], "after reset", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_div_srt_mant.md
FP_DIV_SRT_MANT -- requirements
Module: fp_div_srt_mant

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port in_valid  input  1  operand set valid.
REQ-004 SHALL have port in_ready  output  1  block idle, can accept operands.
REQ-005 SHALL have port dividend_mant  input  23  dividend fraction; hidden 1 implied.
REQ-006 SHALL have port divisor_mant  input  23  divisor fraction; hidden 1 implied.
REQ-007 SHALL have port exp_in  input  8  biased quotient exponent from the upstream exponent stage (fp_div_exp result_exp).
REQ-008 SHALL have port sign_in  input  1  quotient sign, already XORed upstream.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  32  IEEE-754 single {sign, exp, mant}.

Function
REQ-012 SHALL implement FSM states IDLE, ITER, CORR, ROUND, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; transfer occurs on edge with in_valid && in_ready.
REQ-014 On transfer, SHALL capture all operands, clear the iteration counter and enter ITER; later input changes have no effect.
REQ-015 in_valid outside IDLE SHALL be ignored; no operand queuing.
REQ-016 ITER SHALL perform exactly 26 radix-2 SRT iterations, one per cycle, digits {-1,0,+1}, selection from a truncated estimate of the top remainder bits, partial remainder kept in 28-bit two's complement.
REQ-017 Quotient digits SHALL be held as separate positive/negative 26-bit registers (redundant form).
REQ-018 CORR (1 cycle) SHALL form Q = Qpos - Qneg; if final remainder negative, Q decrements by 1 and the divisor is added back to the remainder.
REQ-019 After CORR, Q SHALL equal floor((1.dividend_mant / 1.divisor_mant) * 2^25) exactly, with R the exact non-negative remainder.
REQ-020 ROUND (1 cycle), when Q[25]=1: mant = Q[24:2], guard = Q[1], sticky = Q[0] | (R != 0), exp = exp_in.
REQ-021 ROUND, when Q[25]=0: mant = Q[23:1], guard = Q[0], sticky = (R != 0), exp = exp_in - 1 (mod 256).
REQ-022 Rounding SHALL be round-to-nearest-even: increment when guard && (sticky || mant[0]).
REQ-023 On mantissa rounding overflow, mant SHALL become 0 and exp SHALL increment (mod 256).
REQ-024 Zero/Inf/NaN/denormal operands and exponent overflow/underflow SHALL NOT be detected; exponent arithmetic wraps modulo 256.
REQ-025 Latency: out_valid SHALL go high after the 28th rising edge following the transfer edge (26 ITER + CORR + ROUND).
REQ-026 In DONE, out_valid = 1 and result SHALL stay constant until out_valid && out_ready; that edge returns to IDLE (in_ready = 1 next cycle).
REQ-027 out_ready outside DONE SHALL be ignored.
REQ-028 out_valid SHALL never be high in the same cycle as in_ready.

Reset
REQ-029 rst SHALL force IDLE on the next edge from any state, discarding in-flight operations, and take priority over all handshakes.
REQ-030 Reset values: in_ready = 1 (IDLE), out_valid = 0, result = 32'h0, counter = 0, remainder and quotient registers = 0.
REQ-031 The first transfer SHALL be possible on the first edge where rst = 0 and in_valid = 1.

Verification
REQ-032 1.0/1.0: dividend_mant=0, divisor_mant=0, exp_in=127, sign_in=0 -> result 32'h3F800000 with out_valid exactly 28 cycles after transfer.
REQ-033 1.0/1.5: divisor_mant=23'h400000, exp_in=127 -> result 32'h3F2AAAAB (normalize down, round up).
REQ-034 1.5/1.0 negative: dividend_mant=23'h400000, divisor_mant=0, exp_in=128, sign_in=1 -> result 32'hC0400000.
REQ-035 1.0/(1+2^-23): divisor_mant=1, exp_in=127 -> result 32'h3F7FFFFE (sticky set, round down).
REQ-036 Backpressure: out_ready held 0 for 10 cycles in DONE, in_valid pulsed -> result stable, in_ready 0, pulse ignored; after out_ready=1, IDLE next cycle.
REQ-037 Reset during ITER (iteration 10) -> out_valid 0, in_ready 1 after the reset edge; next operation (REQ-032 stimulus) correct with full 28-cycle latency.
